// File: rtl/disp_pkg.sv
// Shared definitions for the display frame fetcher: state encoding,
// AXI burst-length helper and the default 640x480 frame geometry.
package disp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FRST    = 3'd1,
    ST_WAIT_SP = 3'd2,
    ST_ADDR    = 3'd3,
    ST_DATA    = 3'd4
  } state_t;

  localparam int AXI_LEN_W  = 8;
  localparam int BEAT_BYTES = 8;

  // Default frame geometry: 640x480 pixels, two pixels per 64-bit beat
  localparam int H_PIXELS        = 640;
  localparam int V_LINES         = 480;
  localparam int PIXELS_PER_BEAT = 2;

  localparam int DEF_BURST_BEATS  = 16;
  localparam int DEF_FRAME_BURSTS = (H_PIXELS * V_LINES) / (PIXELS_PER_BEAT * DEF_BURST_BEATS);
  localparam int DEF_RST_CYCLES   = 8;

  // AXI encodes burst length as beats-1
  function automatic logic [AXI_LEN_W-1:0] axi_len(input int beats);
    return AXI_LEN_W'(beats - 1);
  endfunction

  localparam logic [AXI_LEN_W-1:0] DEF_ARLEN = axi_len(DEF_BURST_BEATS);

endpackage

// File: rtl/disp_fetch_addr.sv
// Frame address walker: holds the current burst address and the count of
// completed bursts. load restarts at a new base, advance steps one burst,
// done flags that the frame is (or is becoming, on this advance) complete.
module disp_fetch_addr
  import disp_pkg::*;
#(
  parameter int BURST_BEATS  = DEF_BURST_BEATS,
  parameter int FRAME_BURSTS = DEF_FRAME_BURSTS
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] base,
  input  logic        advance,
  output logic [31:0] addr,
  output logic        done
);

  localparam int          CNT_W = $clog2(FRAME_BURSTS + 1);
  localparam logic [31:0] STEP  = 32'(BURST_BEATS * BEAT_BYTES);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  // Done looks through the advance so the FSM can decide on the RLAST beat
  always_comb begin
    cnt_nxt = cnt + CNT_W'(1);
    done    = ((advance ? cnt_nxt : cnt) == CNT_W'(FRAME_BURSTS));
  end

  // Address and burst count; a load wins over a simultaneous advance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr <= '0;
      cnt  <= '0;
    end else if (load) begin
      addr <= base;
      cnt  <= '0;
    end else if (advance) begin
      addr <= addr + STEP;
      cnt  <= cnt_nxt;
    end
  end

endmodule

// File: rtl/disp_fetch.sv
// Display frame fetcher: on each frame start, pulses the display FIFO reset,
// then reads the frame buffer one AXI burst at a time (only when the FIFO
// has room for a whole burst) and streams the beats into the FIFO.
module disp_fetch
  import disp_pkg::*;
#(
  parameter int BURST_BEATS  = DEF_BURST_BEATS,
  parameter int FRAME_BURSTS = DEF_FRAME_BURSTS,
  parameter int RST_CYCLES   = DEF_RST_CYCLES
) (
  input  logic        ACLK,
  input  logic        ARST,
  input  logic        DISPON,
  input  logic        VSTART,
  input  logic [31:0] DISPADDR,
  input  logic        BUF_WREADY,
  output logic [31:0] ARADDR,
  output logic [7:0]  ARLEN,
  output logic        ARVALID,
  input  logic        ARREADY,
  input  logic [63:0] RDATA,
  input  logic        RVALID,
  input  logic        RLAST,
  output logic        RREADY,
  output logic        FIFORST,
  output logic [63:0] FIFOIN,
  output logic        FIFOWR,
  output logic        LATE
);

  localparam int              RC_W    = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RC_W-1:0] RC_LAST = RC_W'(RST_CYCLES - 1);
  localparam logic [7:0]      LEN     = axi_len(BURST_BEATS);

  state_t          state;
  logic [RC_W-1:0] rst_cnt;
  logic            pending;
  logic            vs_any;
  logic            beat;
  logic            last_beat;
  logic            load;
  logic [31:0]     cur_addr;
  logic            done;

  disp_fetch_addr #(
    .BURST_BEATS  (BURST_BEATS),
    .FRAME_BURSTS (FRAME_BURSTS)
  ) u_addr (
    .clk     (ACLK),
    .rst_n   (ARST),
    .load    (load),
    .base    (DISPADDR),
    .advance (last_beat),
    .addr    (cur_addr),
    .done    (done)
  );

  // Beat qualification and the restart (address relatch) decision
  always_comb begin
    vs_any    = VSTART | pending;
    beat      = (state == ST_DATA) & RVALID & RREADY;
    last_beat = beat & RLAST;
    load      = 1'b0;
    case (state)
      ST_IDLE:             load = VSTART & DISPON;
      ST_FRST, ST_WAIT_SP: load = vs_any & DISPON;
      ST_DATA:             load = last_beat & vs_any & DISPON;
      default:             load = 1'b0;
    endcase
  end

  // Main FSM with registered AXI and FIFO outputs
  always_ff @(posedge ACLK or negedge ARST) begin
    if (!ARST) begin
      state   <= ST_IDLE;
      rst_cnt <= '0;
      pending <= 1'b0;
      ARVALID <= 1'b0;
      ARADDR  <= '0;
      ARLEN   <= '0;
      RREADY  <= 1'b0;
      FIFORST <= 1'b0;
      FIFOWR  <= 1'b0;
      FIFOIN  <= '0;
      LATE    <= 1'b0;
    end else begin
      FIFOWR <= beat;
      if (beat) FIFOIN <= RDATA;
      if (VSTART && (state != ST_IDLE)) LATE <= 1'b1;

      case (state)
        ST_IDLE: begin
          pending <= 1'b0;
          if (load) begin
            state   <= ST_FRST;
            FIFORST <= 1'b1;
            rst_cnt <= '0;
          end
        end

        ST_FRST: begin
          if (!DISPON) begin
            state   <= ST_IDLE;
            FIFORST <= 1'b0;
            pending <= 1'b0;
          end else if (load) begin
            FIFORST <= 1'b1;
            rst_cnt <= '0;
            pending <= 1'b0;
          end else if (!FIFORST) begin
            // Arrived straight from a burst: the last beat is being written
            // this cycle, so the FIFO reset starts one cycle later.
            FIFORST <= 1'b1;
          end else if (rst_cnt == RC_LAST) begin
            FIFORST <= 1'b0;
            state   <= ST_WAIT_SP;
          end else begin
            rst_cnt <= rst_cnt + RC_W'(1);
          end
        end

        ST_WAIT_SP: begin
          if (!DISPON) begin
            state   <= ST_IDLE;
            pending <= 1'b0;
          end else if (load) begin
            state   <= ST_FRST;
            FIFORST <= 1'b1;
            rst_cnt <= '0;
            pending <= 1'b0;
          end else if (BUF_WREADY) begin
            state  <= ST_ADDR;
            ARADDR <= cur_addr;
            ARLEN  <= LEN;
          end
        end

        ST_ADDR: begin
          if (VSTART) pending <= 1'b1;
          if (ARVALID && ARREADY) begin
            ARVALID <= 1'b0;
            RREADY  <= 1'b1;
            state   <= ST_DATA;
          end else begin
            ARVALID <= 1'b1;
          end
        end

        ST_DATA: begin
          if (VSTART) pending <= 1'b1;
          if (last_beat) begin
            RREADY <= 1'b0;
            if (!DISPON) begin
              state   <= ST_IDLE;
              pending <= 1'b0;
            end else if (load) begin
              state   <= ST_FRST;
              rst_cnt <= '0;
              pending <= 1'b0;
            end else if (done) begin
              state <= ST_IDLE;
            end else begin
              state <= ST_WAIT_SP;
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_disp_fetch.sv
// Self-checking bench for disp_fetch: table of full-frame runs plus
// directed sequences for backpressure, late frames, DISPON drop, short
// bursts, VSTART on the final RLAST and reset during a burst.
module tb_disp_fetch;

  localparam int BB = 4;
  localparam int FB = 4;
  localparam int RC = 8;

  logic        ACLK = 1'b0;
  logic        ARST;
  logic        DISPON, VSTART, BUF_WREADY, ARREADY;
  logic [31:0] DISPADDR;
  logic [31:0] ARADDR;
  logic [7:0]  ARLEN;
  logic        ARVALID, RREADY, FIFORST, FIFOWR, LATE;
  logic [63:0] RDATA, FIFOIN;
  logic        RVALID, RLAST;

  int tests  = 0;
  int failed = 0;

  logic [31:0] ar_q[$];
  logic [63:0] wr_q[$];
  int rst_hi    = 0;
  int overlap   = 0;
  int arlen_bad = 0;

  int slave_len  = BB;
  bit rv_en      = 1'b0;
  int beat_idx   = 0;
  int beat_total = 0;
  bit hs         = 1'b0;

  typedef struct packed {
    logic [31:0]       base;
    logic [3:0][31:0]  addr;
  } frame_vec_t;

  frame_vec_t vecs[4];

  always #5 ACLK = ~ACLK;

  disp_fetch #(
    .BURST_BEATS  (BB),
    .FRAME_BURSTS (FB),
    .RST_CYCLES   (RC)
  ) dut (
    .ACLK       (ACLK),
    .ARST       (ARST),
    .DISPON     (DISPON),
    .VSTART     (VSTART),
    .DISPADDR   (DISPADDR),
    .BUF_WREADY (BUF_WREADY),
    .ARADDR     (ARADDR),
    .ARLEN      (ARLEN),
    .ARVALID    (ARVALID),
    .ARREADY    (ARREADY),
    .RDATA      (RDATA),
    .RVALID     (RVALID),
    .RLAST      (RLAST),
    .RREADY     (RREADY),
    .FIFORST    (FIFORST),
    .FIFOIN     (FIFOIN),
    .FIFOWR     (FIFOWR)
    ,.LATE      (LATE)
  );

  // Observe the bus mid-cycle, away from the active edge
  always @(negedge ACLK) begin
    if (ARVALID && ARREADY) begin
      ar_q.push_back(ARADDR);
      if (ARLEN != 8'(BB - 1)) arlen_bad++;
    end
    if (FIFOWR) wr_q.push_back(FIFOIN);
    if (FIFOWR && FIFORST) overlap++;
    if (FIFORST) rst_hi++;
  end

  // Read-data slave: RVALID follows rv_en, RLAST after slave_len beats,
  // RDATA tagged with a running beat number.
  initial begin
    RVALID = 1'b0;
    RLAST  = 1'b0;
    RDATA  = '0;
    forever begin
      @(negedge ACLK);
      hs = RVALID && RREADY;
      @(posedge ACLK);
      #1;
      if (hs) begin
        beat_total++;
        beat_idx = RLAST ? 0 : beat_idx + 1;
      end else if (!RREADY) begin
        beat_idx = 0;
      end
      RVALID = rv_en;
      RLAST  = (beat_idx == slave_len - 1);
      RDATA  = {32'hDA7A_0000, 32'(beat_total)};
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge ACLK);
      #1;
    end
  endtask

  task automatic pulse_vstart(input logic [31:0] base);
    DISPADDR = base;
    VSTART   = 1'b1;
    tick(1);
    VSTART   = 1'b0;
  endtask

  task automatic wait_writes(input int target, input int limit);
    int k = 0;
    while ((wr_q.size() < target) && (k < limit)) begin
      tick(1);
      k++;
    end
  endtask

  task automatic wait_ars(input int target, input int limit);
    int k = 0;
    while ((ar_q.size() < target) && (k < limit)) begin
      tick(1);
      k++;
    end
  endtask

  function automatic logic [31:0] ar_at(input int i);
    if (i < ar_q.size()) return ar_q[i];
    return 32'hBAD0_BAD0;
  endfunction

  function automatic int data_errors(input int w0, input int d0, input int n);
    int bad = 0;
    for (int i = 0; i < n; i++) begin
      if ((w0 + i) >= wr_q.size()) bad++;
      else if (wr_q[w0 + i] !== {32'hDA7A_0000, 32'(d0 + i)}) bad++;
    end
    return bad;
  endfunction

  initial begin
    int a0, w0, r0, d0, k, bad;

    vecs[0] = '{base: 32'h0000_1000, addr: {32'h0000_1060, 32'h0000_1040, 32'h0000_1020, 32'h0000_1000}};
    vecs[1] = '{base: 32'h0000_0080, addr: {32'h0000_00E0, 32'h0000_00C0, 32'h0000_00A0, 32'h0000_0080}};
    vecs[2] = '{base: 32'hFFFF_FF80, addr: {32'hFFFF_FFE0, 32'hFFFF_FFC0, 32'hFFFF_FFA0, 32'hFFFF_FF80}};
    vecs[3] = '{base: 32'h8000_0F80, addr: {32'h8000_0FE0, 32'h8000_0FC0, 32'h8000_0FA0, 32'h8000_0F80}};

    ARST       = 1'b1;
    DISPON     = 1'b1;
    VSTART     = 1'b0;
    BUF_WREADY = 1'b1;
    ARREADY    = 1'b1;
    DISPADDR   = '0;
    rv_en      = 1'b1;
    #2;
    ARST = 1'b0;
    tick(3);

    // Reset state
    check("reset ARVALID", ARVALID, 0);
    check("reset RREADY", RREADY, 0);
    check("reset FIFORST", FIFORST, 0);
    check("reset FIFOWR", FIFOWR, 0);
    check("reset LATE", LATE, 0);
    check("reset ARADDR", ARADDR, 0);
    ARST = 1'b1;
    tick(3);

    // Table of full frames with ARREADY and RVALID held high
    for (int v = 0; v < 4; v++) begin
      a0 = ar_q.size(); w0 = wr_q.size(); r0 = rst_hi; d0 = beat_total;
      pulse_vstart(vecs[v].base);
      wait_writes(w0 + FB * BB, 400);
      tick(30);
      check($sformatf("frame%0d ar count", v), ar_q.size() - a0, FB);
      for (int i = 0; i < FB; i++)
        check($sformatf("frame%0d araddr%0d", v, i), ar_at(a0 + i), vecs[v].addr[i]);
      check($sformatf("frame%0d writes", v), wr_q.size() - w0, FB * BB);
      check($sformatf("frame%0d data", v), data_errors(w0, d0, FB * BB), 0);
      check($sformatf("frame%0d fiforst width", v), rst_hi - r0, RC);
      check($sformatf("frame%0d late", v), LATE, 0);
    end

    // FIFO reset window and buffer backpressure
    BUF_WREADY = 1'b0;
    a0 = ar_q.size(); w0 = wr_q.size(); r0 = rst_hi;
    pulse_vstart(32'h0000_1000);
    check("fiforst rises", FIFORST, 1);
    k = 0;
    for (int i = 0; i < RC + 50; i++) begin
      tick(1);
      if (ARVALID) k++;
    end
    check("bp arvalid held low", k, 0);
    check("bp fiforst width", rst_hi - r0, RC);
    check("bp no writes in window", wr_q.size() - w0, 0);
    BUF_WREADY = 1'b1;
    k = 0;
    do begin
      tick(1);
      k++;
    end while (!ARVALID && (k < 10));
    check("bp arvalid latency", k, 2);
    check("bp araddr", ARADDR, 32'h0000_1000);
    wait_writes(w0 + FB * BB, 400);
    tick(30);
    check("bp ar count", ar_q.size() - a0, FB);

    // Late frame: VSTART during beat 2 of burst 1
    a0 = ar_q.size(); w0 = wr_q.size(); r0 = rst_hi;
    pulse_vstart(32'h0000_2000);
    wait_ars(a0 + 1, 100);
    tick(1);
    DISPADDR = 32'h0000_3000;
    VSTART   = 1'b1;
    tick(1);
    VSTART   = 1'b0;
    wait_writes(w0 + BB + FB * BB, 600);
    tick(30);
    check("late first araddr", ar_at(a0), 32'h0000_2000);
    check("late restart araddr", ar_at(a0 + 1), 32'h0000_3000);
    check("late ar count", ar_q.size() - a0, 1 + FB);
    check("late writes", wr_q.size() - w0, BB + FB * BB);
    check("late two fiforst pulses", rst_hi - r0, 2 * RC);
    check("late flag", LATE, 1);

    // DISPON drop while the address phase is stalled
    ARREADY = 1'b0;
    a0 = ar_q.size(); w0 = wr_q.size();
    pulse_vstart(32'h0000_4000);
    k = 0;
    while (!ARVALID && (k < 100)) begin
      tick(1);
      k++;
    end
    DISPON = 1'b0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (!ARVALID || (ARADDR !== 32'h0000_4000)) bad++;
    end
    check("dispon addr held", bad, 0);
    ARREADY = 1'b1;
    wait_writes(w0 + BB, 100);
    tick(30);
    check("dispon ar count", ar_q.size() - a0, 1);
    check("dispon araddr", ar_at(a0), 32'h0000_4000);
    check("dispon writes", wr_q.size() - w0, BB);
    DISPON = 1'b1;
    tick(20);
    check("dispon idle until vstart", ar_q.size() - a0, 1);

    // Early RLAST: two-beat bursts still end the burst and advance
    slave_len = 2;
    a0 = ar_q.size(); w0 = wr_q.size(); d0 = beat_total;
    pulse_vstart(32'h0000_5000);
    wait_writes(w0 + FB * 2, 400);
    tick(30);
    check("short ar count", ar_q.size() - a0, FB);
    check("short last araddr", ar_at(a0 + 3), 32'h0000_5060);
    check("short writes", wr_q.size() - w0, FB * 2);
    check("short data", data_errors(w0, d0, FB * 2), 0);
    slave_len = BB;
    tick(2);

    // VSTART coinciding with the final RLAST restarts instead of finishing
    a0 = ar_q.size(); w0 = wr_q.size();
    pulse_vstart(32'h0000_7000);
    wait_ars(a0 + FB, 400);
    tick(BB - 1);
    DISPADDR = 32'h0000_7400;
    VSTART   = 1'b1;
    tick(1);
    VSTART   = 1'b0;
    wait_writes(w0 + 2 * FB * BB, 800);
    tick(30);
    check("rlast+vstart ar count", ar_q.size() - a0, 2 * FB);
    check("rlast+vstart restart araddr", ar_at(a0 + FB), 32'h0000_7400);
    check("rlast+vstart writes", wr_q.size() - w0, 2 * FB * BB);

    // Asynchronous reset in the middle of a burst
    a0 = ar_q.size();
    pulse_vstart(32'h0000_6000);
    wait_ars(a0 + 1, 100);
    tick(1);
    #2;
    ARST = 1'b0;
    #1;
    check("arst ARVALID", ARVALID, 0);
    check("arst RREADY", RREADY, 0);
    check("arst FIFOWR", FIFOWR, 0);
    check("arst FIFORST", FIFORST, 0);
    check("arst LATE", LATE, 0);
    check("arst ARADDR", ARADDR, 0);
    check("arst ARLEN", ARLEN, 0);
    check("arst FIFOIN", FIFOIN, 0);
    tick(2);
    ARST = 1'b1;
    a0 = ar_q.size(); w0 = wr_q.size(); r0 = rst_hi;
    tick(40);
    check("post-reset no reads", ar_q.size() - a0, 0);
    check("post-reset no writes", wr_q.size() - w0, 0);
    check("post-reset no fiforst", rst_hi - r0, 0);
    pulse_vstart(32'h0000_1000);
    wait_writes(w0 + FB * BB, 400);
    tick(30);
    check("post-reset frame ar count", ar_q.size() - a0, FB);
    check("post-reset frame first araddr", ar_at(a0), 32'h0000_1000);
    check("post-reset late", LATE, 0);

    check("no write during fiforst", overlap, 0);
    check("arlen on handshakes", arlen_bad, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/disp_fetch.md
DISP_FETCH -- requirements
Module: disp_fetch

Interface
REQ-001 SHALL have parameter BURST_BEATS, default 16, meaning the number of 64-bit beats per read burst.
REQ-002 SHALL have parameter FRAME_BURSTS, default 9600, meaning the bursts per frame (640x480 pixels, 2 pixels per beat).
REQ-003 SHALL have parameter RST_CYCLES, default 8, meaning the FIFORST pulse width in ACLK cycles.
REQ-004 SHALL have port ACLK  in  1  the single clock; all logic is on its rising edge.
REQ-005 SHALL have port ARST  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port DISPON  in  1  display enable.
REQ-007 SHALL have port VSTART  in  1  one-cycle frame-start pulse, already synchronous to ACLK.
REQ-008 SHALL have port DISPADDR  in  32  frame base byte address, 128-byte aligned.
REQ-009 SHALL have port BUF_WREADY  in  1  high when the FIFO has room for one burst.
REQ-010 SHALL have ports ARADDR out 32, ARLEN out 8, ARVALID out 1 and ARREADY in 1, forming the read-address channel.
REQ-011 SHALL have ports RDATA in 64, RVALID in 1, RLAST in 1 and RREADY out 1, forming the read-data channel.
REQ-012 SHALL have ports FIFORST out 1, FIFOIN out 64 and FIFOWR out 1, driving the display FIFO.
REQ-013 SHALL have port LATE  out  1  sticky flag: a frame restarted before its fetch completed.

Function
REQ-014 SHALL implement states IDLE, FRST, WAIT_SP, ADDR, DATA.
REQ-015 IDLE: on VSTART=1 with DISPON=1, SHALL latch DISPADDR as the current address, clear the burst counter and enter FRST.
REQ-016 FRST SHALL drive FIFORST=1 for exactly RST_CYCLES cycles, then enter WAIT_SP.
REQ-017 WAIT_SP SHALL enter ADDR in the cycle after BUF_WREADY=1 is sampled.
REQ-018 ADDR SHALL hold ARVALID=1, ARADDR=current address and ARLEN=BURST_BEATS-1, all stable until the ARVALID&ARREADY handshake.
REQ-019 On the handshake, the block SHALL drop ARVALID the next cycle and enter DATA.
REQ-020 At most one burst SHALL be outstanding at any time.
REQ-021 DATA SHALL hold RREADY=1; each RVALID&RREADY beat SHALL produce FIFOWR=1 with FIFOIN=RDATA one cycle later (registered, latency 1).
REQ-022 On the RLAST beat, the block SHALL add BURST_BEATS*8 to the address (32-bit wrap) and increment the burst counter.
REQ-023 After the RLAST beat, if the counter equals FRAME_BURSTS the block SHALL enter IDLE; otherwise it SHALL enter WAIT_SP.
REQ-024 A beat with RLAST=1 before beat BURST_BEATS SHALL still be written and SHALL end the burst; beats are not padded.
REQ-025 A VSTART outside IDLE SHALL set LATE and be recorded as pending.
REQ-026 In WAIT_SP or FRST, a pending VSTART SHALL restart at once: relatch DISPADDR and enter FRST (FRST restarts its count).
REQ-027 In ADDR or DATA, a pending VSTART SHALL first complete the current burst (handshake and all beats), then restart as in REQ-015.
REQ-028 DISPON=0 in IDLE, FRST or WAIT_SP SHALL return the block to IDLE at the next edge, dropping FIFORST.
REQ-029 DISPON=0 in ADDR or DATA SHALL complete the current burst, then enter IDLE.
REQ-030 VSTART and RLAST in the same cycle SHALL complete the burst and then restart; the burst counter SHALL not reach done.
REQ-031 FIFOWR SHALL never assert while FIFORST=1.
REQ-032 LATE SHALL clear only on reset.

Reset
REQ-033 ARST=0 SHALL immediately force state IDLE and set ARVALID, RREADY, FIFOWR, FIFORST and LATE to 0, ARADDR to 0, ARLEN to 0, FIFOIN to 0, the counter to 0 and pending to 0.
REQ-034 Reset deassertion SHALL take effect synchronously to ACLK; the block performs no activity until the next qualifying VSTART.
REQ-035 A reset during a burst SHALL abandon that burst; the interconnect is reset together with this block.

Structure
REQ-036 A shared package disp_pkg SHALL hold the state encoding, the AXI burst-length constant and the default frame geometry.
REQ-037 A single sub-module, disp_fetch_addr, SHALL hold the address and burst counter with load, advance and done outputs.

Verification
REQ-038 SHALL test the full frame: FRAME_BURSTS=4, BURST_BEATS=4, DISPADDR=0x1000, ARREADY and RVALID always 1 -> ARADDR values 0x1000, 0x1020, 0x1040, 0x1060; 16 FIFOWR pulses; return to IDLE; LATE=0.
REQ-039 SHALL test backpressure: BUF_WREADY=0 for 50 cycles after FRST -> ARVALID stays 0; the first ARVALID appears 2 cycles after BUF_WREADY rises.
REQ-040 SHALL test FIFO reset: VSTART pulse -> FIFORST high for exactly 8 cycles, no FIFOWR in that window.
REQ-041 SHALL test late frame: VSTART during beat 2 of burst 1 -> beats 3-4 still written, then FIFORST pulse, ARADDR=DISPADDR again, LATE=1.
REQ-042 SHALL test DISPON drop: DISPON=0 while ARVALID=1 and ARREADY=0 for 10 cycles -> ARADDR held, burst completes after ARREADY, then IDLE.
REQ-043 SHALL test reset: ARST=0 mid-DATA -> all outputs 0 in the same cycle, no activity until the next VSTART.
